// File: rtl/lv_owt_rx_ctrl.sv
`default_nettype none
// ==== lv_owt_rx_ctrl : one-wire Manchester frame receiver (sync head/tail, cmd, data, CRC8, end tail) ====
// ==== rev 1.0 ====

module crc8_serial (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_new_calc,
  input  logic       i_bit_vld,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic [7:0] crc_q;
  logic [7:0] w_seed;
  logic [7:0] w_next;
  logic       w_fb;

  // x^8 + x^2 + x + 1, MSB first, zero seed; i_new_calc restarts from the seed.
  always_comb begin
    w_seed = i_new_calc ? 8'h00 : crc_q;
    w_fb   = w_seed[7] ^ i_bit;
    w_next = {w_seed[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      crc_q <= 8'h00;
    end else if (i_bit_vld) begin
      crc_q <= w_next;
    end
  end

  assign o_crc = crc_q;
endmodule

module lv_owt_rx_ctrl #(
  parameter int                REG_AW           = 7,
  parameter int                OWT_DATA_BIT_NUM = 8,
  parameter int                OWT_ADCD_BIT_NUM = 10,
  parameter logic [REG_AW-1:0] REQ_ADC_ADDR     = 7'h7F,
  parameter int                HALF_BIT_CYC     = 12,
  parameter int                SYNC_MIN_BITS    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_hv_lv_owt_rx,
  output logic                        o_owt_rx_vld,
  output logic                        o_owt_rx_rd,
  output logic [REG_AW-1:0]           o_owt_rx_addr,
  output logic [OWT_ADCD_BIT_NUM-1:0] o_owt_rx_data,
  output logic                        o_owt_rx_crc_err,
  output logic                        o_owt_rx_frm_err
);
  localparam int CNT_W = 8;
  localparam int PH_W  = $clog2(HALF_BIT_CYC);
  localparam int TMR_W = $clog2(8 * HALF_BIT_CYC + 1);

  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(HALF_BIT_CYC / 2 - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF_BIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(4 * HALF_BIT_CYC - 1);
  localparam logic [TMR_W-1:0] ERR_LAST  = TMR_W'(8 * HALF_BIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_TAIL = 3'd2;
  localparam logic [2:0] S_CMD  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CRC  = 3'd5;
  localparam logic [2:0] S_END  = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  logic                        sync1_q, rx_q, prev_q;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic [TMR_W-1:0]            tmr_q, tmr_d;
  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        half_q, half_d;
  logic                        first_q, first_d;
  logic                        adc_q, adc_d;
  logic [REG_AW:0]             cmd_q, cmd_d;
  logic [OWT_ADCD_BIT_NUM-1:0] dat_q, dat_d;
  logic [7:0]                  rcrc_q, rcrc_d;
  logic                        vld_q, vld_d;
  logic                        frm_q, frm_d;
  logic                        rd_q, rd_d;
  logic [REG_AW-1:0]           addr_q, addr_d;
  logic [OWT_ADCD_BIT_NUM-1:0] data_q, data_d;
  logic                        cerr_q, cerr_d;

  logic                        w_edge, w_rise, w_smp, w_bit_ok, w_err, w_crc_vld, w_new_calc;
  logic [REG_AW:0]             w_cmd_next;
  logic [CNT_W-1:0]            w_data_last;
  logic [7:0]                  w_crc;

  assign w_edge      = rx_q ^ prev_q;
  assign w_rise      = rx_q & ~prev_q;
  assign w_smp       = (phase_q == PH_SAMPLE);
  // A Manchester bit completes on its second half sample; the bit value is the first half.
  assign w_bit_ok    = w_smp && half_q && (first_q != rx_q);
  assign w_cmd_next  = {cmd_q[REG_AW-1:0], first_q};
  assign w_data_last = adc_q ? CNT_W'(OWT_ADCD_BIT_NUM - 1) : CNT_W'(OWT_DATA_BIT_NUM - 1);
  assign w_crc_vld   = w_bit_ok && ((state_q == S_CMD) || (state_q == S_DATA));
  assign w_new_calc  = (state_q == S_CMD) && (cnt_q == '0);

  assign phase_d = (w_edge || (phase_q == PH_LAST)) ? '0 : phase_q + PH_W'(1);

  crc8_serial u_crc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_new_calc (w_new_calc),
    .i_bit_vld  (w_crc_vld),
    .i_bit      (first_q),
    .o_crc      (w_crc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    first_d = first_q;
    adc_d   = adc_q;
    cmd_d   = cmd_q;
    dat_d   = dat_q;
    rcrc_d  = rcrc_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cerr_d  = cerr_q;
    vld_d   = 1'b0;
    frm_d   = 1'b0;
    w_err   = 1'b0;
    tmr_d   = w_edge ? '0 : ((tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1));

    if ((state_q != S_IDLE) && (state_q != S_ERR) && !w_edge && (tmr_q == TMO_LAST))
      w_err = 1'b1;

    if (((state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CRC)) && w_smp) begin
      half_d = ~half_q;
      if (!half_q)               first_d = rx_q;
      else if (first_q == rx_q)  w_err   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (w_rise) begin
          state_d = S_HEAD;
          cnt_d   = '0;
          half_d  = 1'b1;
        end
      end
      // half_q set means the high half of a zero head bit is expected next.
      S_HEAD: if (w_smp) begin
        if (half_q) begin
          if (rx_q) begin
            half_d = 1'b0;
            if (cnt_q < CNT_W'(SYNC_MIN_BITS)) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            w_err = 1'b1;
          end
        end else if (!rx_q) begin
          half_d = 1'b1;
        end else if (cnt_q >= CNT_W'(SYNC_MIN_BITS)) begin
          state_d = S_TAIL;
          cnt_d   = '0;
        end else begin
          w_err = 1'b1;
        end
      end
      S_TAIL: if (w_smp) begin
        if (rx_q != (cnt_q == '0)) begin
          w_err = 1'b1;
        end else if (cnt_q == CNT_W'(2)) begin
          state_d = S_CMD;
          cnt_d   = '0;
          half_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CMD: if (w_bit_ok) begin
        cmd_d = w_cmd_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(REG_AW)) begin
          state_d = S_DATA;
          cnt_d   = '0;
          dat_d   = '0;
          adc_d   = (w_cmd_next[REG_AW-1:0] == REQ_ADC_ADDR);
        end
      end
      S_DATA: if (w_bit_ok) begin
        dat_d = {dat_q[OWT_ADCD_BIT_NUM-2:0], first_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == w_data_last) begin
          state_d = S_CRC;
          cnt_d   = '0;
        end
      end
      S_CRC: if (w_bit_ok) begin
        rcrc_d = {rcrc_q[6:0], first_q};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          state_d = S_END;
          cnt_d   = '0;
        end
      end
      S_END: if (w_smp) begin
        if (rx_q != (cnt_q < CNT_W'(2))) begin
          w_err = 1'b1;
        end else if (cnt_q == CNT_W'(3)) begin
          vld_d   = 1'b1;
          rd_d    = cmd_q[REG_AW];
          addr_d  = cmd_q[REG_AW-1:0];
          data_d  = dat_q;
          cerr_d  = (w_crc != rcrc_q);
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        if (rx_q) begin
          tmr_d = '0;
        end else if (tmr_q == ERR_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An abort always wins over a completing frame: no vld and no output update.
    if (w_err) begin
      state_d = S_ERR;
      frm_d   = 1'b1;
      tmr_d   = '0;
      vld_d   = 1'b0;
      rd_d    = rd_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cerr_d  = cerr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      rx_q    <= 1'b0;
      prev_q  <= 1'b0;
      phase_q <= '0;
      tmr_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      first_q <= 1'b0;
      adc_q   <= 1'b0;
      cmd_q   <= '0;
      dat_q   <= '0;
      rcrc_q  <= '0;
      vld_q   <= 1'b0;
      frm_q   <= 1'b0;
      rd_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      cerr_q  <= 1'b0;
    end else begin
      sync1_q <= i_hv_lv_owt_rx;
      rx_q    <= sync1_q;
      prev_q  <= rx_q;
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      first_q <= first_d;
      adc_q   <= adc_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      rcrc_q  <= rcrc_d;
      vld_q   <= vld_d;
      frm_q   <= frm_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cerr_q  <= cerr_d;
    end
  end

  assign o_owt_rx_vld     = vld_q;
  assign o_owt_rx_frm_err = frm_q;
  assign o_owt_rx_rd      = rd_q;
  assign o_owt_rx_addr    = addr_q;
  assign o_owt_rx_data    = data_q;
  assign o_owt_rx_crc_err = cerr_q;
endmodule

`default_nettype wire

// File: tb/tb_lv_owt_rx_ctrl.sv
`default_nettype none
// Bench for lv_owt_rx_ctrl: table vectors, random frames against a frame-level model, corner sequences.
module tb_lv_owt_rx_ctrl;
  localparam int HB = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic       vld, rd, cerr, frm;
  logic [6:0] addr;
  logic [9:0] data;

  always #5 clk = ~clk;

  lv_owt_rx_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_hv_lv_owt_rx   (line),
    .o_owt_rx_vld     (vld),
    .o_owt_rx_rd      (rd),
    .o_owt_rx_addr    (addr),
    .o_owt_rx_data    (data),
    .o_owt_rx_crc_err (cerr),
    .o_owt_rx_frm_err (frm)
  );

  typedef struct {
    int         head;
    logic       rd;
    logic [6:0] addr;
    logic [9:0] data;
    logic       flip;
    int         exp_vld;
    int         exp_frm;
  } vec_t;

  vec_t       tbl[7];
  bit         hq[$];
  int         errors = 0;
  int         checks = 0;
  int         vld_cnt = 0;
  int         frm_cnt = 0;
  logic       exp_rd;
  logic [6:0] exp_addr;
  logic [9:0] exp_data;
  logic       exp_cerr;

  always @(negedge clk) begin
    if (vld) vld_cnt++;
    if (frm) frm_cnt++;
    if (vld || frm) begin
      checks++;
      if (vld && frm) begin
        errors++;
        $display("FAIL vld_frm_excl: vld=%0b frm_err=%0b required not both", vld, frm);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int dlen(input logic [6:0] a);
    return (a == 7'h7F) ? 10 : 8;
  endfunction

  // Remainder of msg(x)*x^8 divided by x^8+x^2+x+1, by long division.
  function automatic logic [7:0] ref_crc(input logic [63:0] msg, input int n);
    logic [71:0] r;
    r = {msg, 8'h00};
    for (int i = n + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic push_bit(input logic b);
    hq.push_back(b);
    hq.push_back(!b);
  endtask

  task automatic push_nrz_tail();
    hq.push_back(1'b1); hq.push_back(1'b1); hq.push_back(1'b0); hq.push_back(1'b0);
  endtask

  task automatic build(input int head, input logic r, input logic [6:0] a,
                       input logic [9:0] d, input logic flip);
    int          n;
    logic [63:0] msg;
    logic [7:0]  crc;
    hq.delete();
    n   = dlen(a);
    msg = ({56'd0, r, a} << n) | {54'd0, d};
    crc = ref_crc(msg, 8 + n) ^ {7'd0, flip};
    for (int i = 0; i < head; i++) push_bit(1'b0);
    push_nrz_tail();
    for (int i = n + 7; i >= 0; i--) push_bit(msg[i]);
    for (int i = 7; i >= 0; i--) push_bit(crc[i]);
    push_nrz_tail();
  endtask

  task automatic hold(input logic v, input int cyc);
    line = v;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) hold(hq[i], HB);
  endtask

  task automatic check_outputs(input string tag, input int v0, input int f0,
                               input int ev, input int ef);
    chk({tag, "_vld_cnt"}, 32'(vld_cnt - v0), 32'(ev));
    chk({tag, "_frm_cnt"}, 32'(frm_cnt - f0), 32'(ef));
    chk({tag, "_rd"},   {31'd0, rd},   {31'd0, exp_rd});
    chk({tag, "_addr"}, {25'd0, addr}, {25'd0, exp_addr});
    chk({tag, "_data"}, {22'd0, data}, {22'd0, exp_data});
    chk({tag, "_crc_err"}, {31'd0, cerr}, {31'd0, exp_cerr});
  endtask

  task automatic run_frame(input string tag, input int head, input logic r, input logic [6:0] a,
                           input logic [9:0] d, input logic flip, input int ev, input int ef,
                           input int gap);
    int v0, f0;
    v0 = vld_cnt;
    f0 = frm_cnt;
    build(head, r, a, d, flip);
    play(hq.size());
    hold(1'b0, gap);
    if (ev != 0) begin
      exp_rd   = r;
      exp_addr = a;
      exp_data = d;
      exp_cerr = flip;
    end
    check_outputs(tag, v0, f0, ev, ef);
  endtask

  initial begin
    int         v0, f0;
    int         head;
    logic       r, flip;
    logic [6:0] a;
    logic [9:0] d;

    tbl[0] = '{12, 1'b0, 7'h05, 10'h0A5, 1'b0, 1, 0};
    tbl[1] = '{12, 1'b1, 7'h7F, 10'h2C3, 1'b0, 1, 0};
    tbl[2] = '{12, 1'b0, 7'h05, 10'h0A5, 1'b1, 1, 0};
    tbl[3] = '{ 3, 1'b0, 7'h05, 10'h0A5, 1'b0, 0, 1};
    tbl[4] = '{12, 1'b0, 7'h05, 10'h0A5, 1'b0, 1, 0};
    tbl[5] = '{ 4, 1'b1, 7'h7E, 10'h0FF, 1'b0, 1, 0};
    tbl[6] = '{ 5, 1'b0, 7'h7F, 10'h3FF, 1'b1, 1, 0};

    rst_n = 1'b0;
    line  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 10);
    exp_rd = 1'b1; exp_addr = '0; exp_data = '0; exp_cerr = 1'b0;
    check_outputs("reset", 0, 0, 0, 0);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].head, tbl[i].rd, tbl[i].addr, tbl[i].data,
                tbl[i].flip, tbl[i].exp_vld, tbl[i].exp_frm, 130);

    for (int k = 0; k < 20; k++) begin
      head = int'($urandom_range(4, 14));
      r    = 1'($urandom);
      a    = ($urandom_range(0, 2) == 0) ? 7'h7F : 7'($urandom);
      d    = 10'($urandom);
      if (dlen(a) == 8) d[9:8] = 2'b00;
      flip = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", k), head, r, a, d, flip, 1, 0,
                20 + int'($urandom_range(0, 40)));
    end

    // Line stuck high inside DATA.
    v0 = vld_cnt; f0 = frm_cnt;
    build(12, 1'b0, 7'h05, 10'h0A5, 1'b0);
    play(24 + 4 + 16 + 6);
    hold(1'b1, 60);
    hold(1'b0, 130);
    check_outputs("timeout", v0, f0, 0, 1);

    // Invalid Manchester pair 11 as the first CMD bit.
    v0 = vld_cnt; f0 = frm_cnt;
    build(12, 1'b0, 7'h05, 10'h0A5, 1'b0);
    play(24 + 4);
    hold(1'b1, 2 * HB);
    hold(1'b0, 130);
    check_outputs("pair11", v0, f0, 0, 1);

    // Reset in the middle of the CRC field, then a clean frame.
    v0 = vld_cnt; f0 = frm_cnt;
    build(12, 1'b1, 7'h33, 10'h05A, 1'b0);
    play(24 + 4 + 16 + 16 + 6);
    line  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 30);
    exp_rd = 1'b1; exp_addr = '0; exp_data = '0; exp_cerr = 1'b0;
    check_outputs("rst_mid", v0, f0, 0, 0);
    run_frame("post_rst", 12, 1'b0, 7'h12, 10'h03C, 1'b0, 1, 0, 130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
